// File: rtl/keyreg_pkg.sv
// =============================================================================
// Module      : keyreg_pkg
// Description : Shared alarm-clock constants and digit type.
// Revision    : 1.0
// =============================================================================
`default_nettype none

package keyreg_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t DIGIT_ZERO = '0;

endpackage : keyreg_pkg

`default_nettype wire

// File: rtl/keyreg_digit.sv
// =============================================================================
// Module      : keyreg_digit
// Description : One enable-loaded digit register with synchronous reset.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module keyreg_digit
    import keyreg_pkg::*;
#(
    parameter int WIDTH = DIGIT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= WIDTH'(DIGIT_ZERO);
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : keyreg_digit

`default_nettype wire

// File: rtl/keyreg.sv
// =============================================================================
// Module      : keyreg
// Description : Four-digit keypad entry buffer (HH:MM BCD, oldest key in ms_hr).
// Revision    : 1.0
// =============================================================================
`default_nettype none

module keyreg
    import keyreg_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               shift,
    input  logic [DIGIT_W-1:0] key,
    output logic [DIGIT_W-1:0] key_buffer_ls_min,
    output logic [DIGIT_W-1:0] key_buffer_ms_min,
    output logic [DIGIT_W-1:0] key_buffer_ls_hr,
    output logic [DIGIT_W-1:0] key_buffer_ms_hr
);

    localparam int c_NUM_DIGITS = 4;

    // Index 0 is the newest digit (ls_min), index 3 the oldest (ms_hr).
    logic [DIGIT_W-1:0] w_d [c_NUM_DIGITS];
    logic [DIGIT_W-1:0] w_q [c_NUM_DIGITS];

    assign w_d[0] = key;

    generate
        for (genvar gi = 0; gi < c_NUM_DIGITS; gi++) begin : g_stage
            if (gi > 0) begin : g_chain
                assign w_d[gi] = w_q[gi-1];
            end

            keyreg_digit #(
                .WIDTH (DIGIT_W)
            ) u_digit (
                .clk  (clock),
                .rst  (reset),
                .i_en (shift),
                .i_d  (w_d[gi]),
                .o_q  (w_q[gi])
            );
        end
    endgenerate

    assign key_buffer_ls_min = w_q[0];
    assign key_buffer_ms_min = w_q[1];
    assign key_buffer_ls_hr  = w_q[2];
    assign key_buffer_ms_hr  = w_q[3];

endmodule : keyreg

`default_nettype wire

// File: tb/tb_keyreg.sv
// =============================================================================
// Module      : tb_keyreg
// Description : Scoreboard bench for keyreg using directed, hand-computed vectors.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module tb_keyreg;

    logic       clock;
    logic       reset;
    logic       shift;
    logic [3:0] key;
    logic [3:0] key_buffer_ls_min;
    logic [3:0] key_buffer_ms_min;
    logic [3:0] key_buffer_ls_hr;
    logic [3:0] key_buffer_ms_hr;

    keyreg #(
        .DIGIT_W (4)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .shift             (shift),
        .key               (key),
        .key_buffer_ls_min (key_buffer_ls_min),
        .key_buffer_ms_min (key_buffer_ms_min),
        .key_buffer_ls_hr  (key_buffer_ls_hr),
        .key_buffer_ms_hr  (key_buffer_ms_hr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected buffer packed as {ms_hr, ls_hr, ms_min, ls_min}, one hex digit each.
    logic [15:0] exp_q [$];
    string       name_q [$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          n_pushed = 0;
    logic [15:0] mon_exp;
    logic [15:0] mon_got;
    string       mon_name;

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_got  = {key_buffer_ms_hr, key_buffer_ls_hr,
                        key_buffer_ms_min, key_buffer_ls_min};
            tests_run++;
            if (mon_got !== mon_exp) begin
                tests_failed++;
                $display("FAIL %s: got %h required %h", mon_name, mon_got, mon_exp);
            end
        end
    end

    task automatic vec(input logic r, input logic s, input logic [3:0] k,
                       input logic [15:0] e, input string nm);
        @(negedge clock);
        reset = r;
        shift = s;
        key   = k;
        @(posedge clock);
        #1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        n_pushed++;
    endtask

    initial begin
        reset = 1'b1;
        shift = 1'b0;
        key   = 4'h0;

        vec(1'b1, 1'b0, 4'h0, 16'h0000, "initial_reset");
        vec(1'b0, 1'b1, 4'h9, 16'h0009, "preload_a");
        vec(1'b0, 1'b1, 4'h8, 16'h0098, "preload_b");
        vec(1'b1, 1'b0, 4'h6, 16'h0000, "reset_clears");

        vec(1'b0, 1'b1, 4'h1, 16'h0001, "entry_1");
        vec(1'b0, 1'b0, 4'h1, 16'h0001, "entry_1_hold");
        vec(1'b0, 1'b1, 4'h2, 16'h0012, "entry_2");
        vec(1'b0, 1'b0, 4'h2, 16'h0012, "entry_2_hold");
        vec(1'b0, 1'b1, 4'h3, 16'h0123, "entry_3");
        vec(1'b0, 1'b0, 4'h3, 16'h0123, "entry_3_hold");
        vec(1'b0, 1'b1, 4'h4, 16'h1234, "entry_4");
        vec(1'b0, 1'b0, 4'h4, 16'h1234, "entry_4_hold");

        for (int i = 0; i < 10; i++) begin
            vec(1'b0, 1'b0, (i % 2 == 0) ? 4'hF : 4'h5, 16'h1234, "hold_toggle");
        end

        vec(1'b0, 1'b1, 4'h5, 16'h2345, "overflow");
        vec(1'b1, 1'b1, 4'h7, 16'h0000, "reset_priority");

        vec(1'b0, 1'b1, 4'h9, 16'h0009, "held_shift_1");
        vec(1'b0, 1'b1, 4'h9, 16'h0099, "held_shift_2");
        vec(1'b0, 1'b1, 4'h9, 16'h0999, "held_shift_3");
        vec(1'b0, 1'b0, 4'h0, 16'h0999, "held_shift_release");

        vec(1'b0, 1'b1, 4'hF, 16'h999F, "unfiltered_key");
        vec(1'b0, 1'b1, 4'hA, 16'h99FA, "unfiltered_key_2");
        vec(1'b1, 1'b0, 4'h0, 16'h0000, "reset_mid_entry");
        vec(1'b0, 1'b1, 4'h2, 16'h0002, "restart_entry");

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
            @(posedge clock);
        end
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        if (tests_run != n_pushed) begin
            tests_failed++;
            $display("FAIL check_count: got %0d required %0d", tests_run, n_pushed);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_keyreg

`default_nettype wire
